// File: rtl/data_memory_if.sv
// CPU MEM-stage data bus: address/strobes/write data from the pipeline,
// combinational read data back to the MEM/WB register.
interface data_memory_if;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output read_enable, write_enable, address, writedata,
    input  readdata
  );

  modport slave (
    input  read_enable, write_enable, address, writedata,
    output readdata
  );
endinterface

// File: rtl/data_memory.sv
// Data-memory stage: word RAM plus memory-mapped timer, LED, switch,
// 7-segment tube and an 8N1 UART. Reads are combinational, writes on clk.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a TXD write
// TX_START | driving the start bit (0)
// TX_DATA  | shifting out data bits, LSB first
// TX_STOP  | driving the stop bit (1); tx-done set on exit
// RX_IDLE  | waiting for a high-to-low edge on the synchronized line
// RX_START | half-bit wait, then re-check start bit (glitch filter)
// RX_DATA  | sampling 8 data bits at bit centres
// RX_STOP  | sampling stop bit; 1 delivers the byte, 0 drops it
module data_memory #(
  parameter int RAM_WORDS = 256,
  parameter int BAUD_DIV  = 434
) (
  input  logic          clk,
  input  logic          reset,
  data_memory_if.slave  bus,
  input  logic [7:0]    switch,
  input  logic          Uart_Rx,
  output logic [7:0]    led,
  output logic [17:0]   tube,
  output logic          Uart_Tx,
  output logic          if_continue,
  output logic          irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_TUBE = 32'h4000_0014;
  localparam logic [31:0] A_TXD  = 32'h4000_0018;
  localparam logic [31:0] A_RXD  = 32'h4000_001C;
  localparam logic [31:0] A_CON  = 32'h4000_0020;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] addr_w, th, tl;
  logic [2:0]  tcon;
  logic [AW-1:0] ram_idx;
  logic        in_ram, unused_addr_lsb;
  logic [7:0]  txd_reg, rxd_reg;
  logic [1:0]  con_en;
  logic        tx_done, rx_done, tx_busy;
  logic        txd_wr, con_rd, rxd_rd;

  tx_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_done_set;

  rx_state_t   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done_set, rx_s1, rx_s2, rx_prev;

  assign addr_w          = {bus.address[31:2], 2'b00};
  assign unused_addr_lsb = ^bus.address[1:0];
  assign in_ram          = bus.address[31:2] < 30'(RAM_WORDS);
  assign ram_idx         = bus.address[AW+1:2];
  assign tx_busy         = (tx_state != TX_IDLE);
  assign txd_wr = bus.write_enable && (addr_w == A_TXD) && !tx_busy;
  assign con_rd = bus.read_enable && (addr_w == A_CON);
  assign rxd_rd = bus.read_enable && (addr_w == A_RXD);
  assign irq    = tcon[1] & tcon[2];
  assign Uart_Tx = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  // RAM write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (bus.write_enable && in_ram) ram[ram_idx] <= bus.writedata;
  end

  // Combinational read mux, zero when not reading or unmapped
  always_comb begin
    bus.readdata = '0;
    if (bus.read_enable) begin
      if (in_ram) bus.readdata = ram[ram_idx];
      else begin
        case (addr_w)
          A_TH:    bus.readdata = th;
          A_TL:    bus.readdata = tl;
          A_TCON:  bus.readdata = {29'b0, tcon};
          A_LED:   bus.readdata = {24'b0, led};
          A_SW:    bus.readdata = {24'b0, switch};
          A_TUBE:  bus.readdata = {14'b0, tube};
          A_TXD:   bus.readdata = {24'b0, txd_reg};
          A_RXD:   bus.readdata = {24'b0, rxd_reg};
          A_CON:   bus.readdata = {27'b0, tx_busy, rx_done, tx_done, con_en};
          default: bus.readdata = '0;
        endcase
      end
    end
  end

  // Timer: CPU writes to TL/TCON take priority over the counting update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0; tl <= '0; tcon <= '0;
    end else begin
      if (bus.write_enable && addr_w == A_TH) th <= bus.writedata;
      if (bus.write_enable && addr_w == A_TL) tl <= bus.writedata;
      else if (tcon[0]) tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
      if (bus.write_enable && addr_w == A_TCON) tcon <= bus.writedata[2:0];
      else if (tcon[0] && tcon[1] && tl == 32'hFFFF_FFFF) tcon[2] <= 1'b1;
    end
  end

  // Peripheral registers and sticky UART flags; a set beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= '0; tube <= '0; con_en <= '0; txd_reg <= '0; rxd_reg <= '0;
      tx_done <= 1'b0; rx_done <= 1'b0; if_continue <= 1'b0;
    end else begin
      if (bus.write_enable) begin
        case (addr_w)
          A_LED:   led    <= bus.writedata[7:0];
          A_TUBE:  tube   <= bus.writedata[17:0];
          A_CON:   con_en <= bus.writedata[1:0];
          default: ;
        endcase
      end
      if (txd_wr) txd_reg <= bus.writedata[7:0];
      if (tx_done_set) tx_done <= 1'b1;
      else if (con_rd) tx_done <= 1'b0;
      if (rx_done_set) rx_done <= 1'b1;
      else if (con_rd) rx_done <= 1'b0;
      if (rx_done_set) begin
        rxd_reg     <= rx_shift;
        if_continue <= 1'b1;
      end else if (rxd_rd) if_continue <= 1'b0;
    end
  end

  // UART state registers and RX line synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_shift <= '0;
      rx_state <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_shift <= '0;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n; tx_shift <= tx_shift_n;
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n; rx_shift <= rx_shift_n;
      rx_s1 <= Uart_Rx; rx_s2 <= rx_s1; rx_prev <= rx_s2;
    end
  end

  // TX next state: each bit held for BAUD_DIV clks via a down-counter
  always_comb begin
    tx_state_n = tx_state; tx_cnt_n = tx_cnt; tx_bit_n = tx_bit;
    tx_shift_n = tx_shift; tx_done_set = 1'b0;
    case (tx_state)
      TX_IDLE: if (txd_wr) begin
        tx_state_n = TX_START; tx_cnt_n = BIT_LAST;
        tx_bit_n = '0; tx_shift_n = bus.writedata[7:0];
      end
      TX_START: if (tx_cnt == '0) begin
        tx_state_n = TX_DATA; tx_cnt_n = BIT_LAST;
      end else tx_cnt_n = tx_cnt - 1'b1;
      TX_DATA: if (tx_cnt == '0) begin
        tx_cnt_n = BIT_LAST; tx_bit_n = tx_bit + 3'd1;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
      end else tx_cnt_n = tx_cnt - 1'b1;
      TX_STOP: if (tx_cnt == '0) begin
        tx_state_n = TX_IDLE; tx_done_set = 1'b1;
      end else tx_cnt_n = tx_cnt - 1'b1;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // RX next state: half-bit to the start centre, then full bits
  always_comb begin
    rx_state_n = rx_state; rx_cnt_n = rx_cnt; rx_bit_n = rx_bit;
    rx_shift_n = rx_shift; rx_done_set = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) begin
        rx_state_n = RX_START; rx_cnt_n = HALF_LAST;
      end
      RX_START: if (rx_cnt == '0) begin
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        rx_cnt_n = BIT_LAST; rx_bit_n = '0;
      end else rx_cnt_n = rx_cnt - 1'b1;
      RX_DATA: if (rx_cnt == '0) begin
        rx_cnt_n = BIT_LAST; rx_bit_n = rx_bit + 3'd1;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end else rx_cnt_n = rx_cnt - 1'b1;
      RX_STOP: if (rx_cnt == '0) begin
        rx_state_n = RX_IDLE; rx_done_set = rx_s2;
      end else rx_cnt_n = rx_cnt - 1'b1;
      default: rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected values, a
// negedge monitor pops and compares on every read or output probe.
module tb_data_memory;
  localparam int BD = 4;
  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008, A_LED = 32'h4000_000C;
  localparam logic [31:0] A_SW = 32'h4000_0010, A_TUBE = 32'h4000_0014;
  localparam logic [31:0] A_TXD = 32'h4000_0018, A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam int S_RD = 0, S_LED = 1, S_TUBE = 2, S_TX = 3, S_IFC = 4, S_IRQ = 5;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] switch, led;
  logic Uart_Rx, Uart_Tx, if_continue, irq;
  logic [17:0] tube;

  data_memory_if bus();

  data_memory #(.RAM_WORDS(256), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .switch(switch),
    .Uart_Rx(Uart_Rx), .led(led), .tube(tube), .Uart_Tx(Uart_Tx),
    .if_continue(if_continue), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic probe = 1'b0;
  item_t mon_it;
  logic [31:0] mon_act;

  always @(negedge clk) begin
    if (bus.read_enable || probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: no expected entry queued");
      end else begin
        mon_it = exp_q.pop_front();
        case (mon_it.sel)
          S_RD:    mon_act = bus.readdata;
          S_LED:   mon_act = {24'b0, led};
          S_TUBE:  mon_act = {14'b0, tube};
          S_TX:    mon_act = {31'b0, Uart_Tx};
          S_IFC:   mon_act = {31'b0, if_continue};
          S_IRQ:   mon_act = {31'b0, irq};
          default: mon_act = 'x;
        endcase
        if (mon_act !== mon_it.exp) begin
          errors++;
          $display("FAIL %s: actual=%h required=%h", mon_it.name, mon_act, mon_it.exp);
        end
      end
    end
  end

  task automatic push(input int s, input logic [31:0] e, input string n);
    item_t it;
    it.sel = s; it.exp = e; it.name = n;
    exp_q.push_back(it);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write_enable = 1'b1;
    @(posedge clk); #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    bus.address = a; bus.read_enable = 1'b1;
    push(S_RD, e, n);
    @(posedge clk); #1;
    bus.read_enable = 1'b0;
  endtask

  task automatic chk(input int s, input logic [31:0] e, input string n);
    push(s, e, n);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Uart_Rx = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    Uart_Rx = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    reset = 1'b1; switch = 8'h00; Uart_Rx = 1'b1;
    bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    bus.address = '0; bus.writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    chk(S_LED, 32'h0, "rst_led");
    chk(S_TUBE, 32'h0, "rst_tube");
    chk(S_TX, 32'h1, "rst_uart_tx");
    chk(S_IFC, 32'h0, "rst_if_continue");
    chk(S_IRQ, 32'h0, "rst_irq");
    rd(A_CON, 32'h0, "rst_uart_con");
    rd(A_TCON, 32'h0, "rst_tcon");
    rd(A_RXD, 32'h0, "rst_rxd");

    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd_10");
    rd(32'h14, 32'h1234_5678, "ram_rd_14");
    rd(32'h12, 32'hDEAD_BEEF, "ram_rd_12_lsb_ignored");
    bus.address = 32'h10;
    chk(S_RD, 32'h0, "rd_disabled_zero");

    wr(A_LED, 32'h1A5);
    chk(S_LED, 32'hA5, "led_out");
    rd(A_LED, 32'hA5, "led_rd");
    wr(A_TUBE, 32'h3FFFF);
    chk(S_TUBE, 32'h3FFFF, "tube_out");
    switch = 8'h5C;
    rd(A_SW, 32'h5C, "switch_rd");
    rd(32'h4000_0100, 32'h0, "unmapped_rd");

    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    idle(2);
    rd(A_TL, 32'hFFFF_FFFD, "timer_reload");
    chk(S_IRQ, 32'h1, "timer_irq_set");
    wr(A_TCON, 32'h1);
    chk(S_IRQ, 32'h0, "timer_irq_cleared");
    rd(A_TCON, 32'h1, "tcon_rd");
    rd(A_TL, 32'hFFFF_FFFF, "timer_keeps_counting");
    wr(A_TCON, 32'h0);

    chk(S_TX, 32'h1, "tx_idle_high");
    frame = {1'b1, 8'h55, 1'b0};
    wr(A_TXD, 32'h55);
    for (int k = 0; k < 10 * BD; k++) begin
      if (k == 20) rd(A_CON, 32'h10, "tx_busy_flag");
      else chk(S_TX, {31'b0, frame[k / BD]}, $sformatf("tx_bit_c%0d", k));
    end
    rd(A_CON, 32'h04, "tx_done_flag");
    rd(A_CON, 32'h00, "tx_done_cleared");

    send_rx(8'hA3, 1'b1);
    idle(3);
    chk(S_IFC, 32'h1, "rx_if_continue_set");
    rd(A_CON, 32'h08, "rx_done_flag");
    rd(A_RXD, 32'hA3, "rx_data");
    chk(S_IFC, 32'h0, "rx_if_continue_cleared");
    send_rx(8'h3C, 1'b0);
    idle(3);
    chk(S_IFC, 32'h0, "rx_framing_no_flag");
    rd(A_RXD, 32'hA3, "rx_framing_rxd_kept");
    rd(A_CON, 32'h00, "rx_framing_con");

    wr(A_CON, 32'h3);
    wr(A_TXD, 32'hF0);
    idle(5);
    chk(S_TX, 32'h0, "tx_mid_frame_low");
    #2 reset = 1'b1;
    chk(S_TX, 32'h1, "midreset_uart_tx");
    chk(S_LED, 32'h0, "midreset_led");
    chk(S_TUBE, 32'h0, "midreset_tube");
    rd(A_CON, 32'h0, "midreset_uart_con");
    reset = 1'b0;
    idle(2);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expected: actual=%0d entries required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data-memory stage of the 5-stage MIPS pipeline: word-addressed RAM plus memory-mapped peripherals (timer, LEDs, switches, 7-segment tube, UART).
- CPU MEM stage drives address, read/write enables and write data; read data returns combinationally for the MEM/WB register.
- Single clock domain, clk; UART bit timing is derived from clk.

Parameters:
- RAM_WORDS, 256, RAM depth in 32-bit words; byte addresses 0x0 to 4*RAM_WORDS-1.
- BAUD_DIV, 434, clk cycles per UART bit.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- read_enable  input  1  read strobe.
- write_enable  input  1  write strobe.
- address  input  32  byte address; bits [1:0] ignored.
- writedata  input  32  write data.
- switch  input  8  board switches.
- Uart_Rx  input  1  UART receive line, idle high.
- readdata  output  32  read data.
- led  output  8  LED register.
- tube  output  18  7-segment drive register.
- Uart_Tx  output  1  UART transmit line.
- if_continue  output  1  received byte pending (RX valid).
- irq  output  1  timer interrupt request.

Behaviour:
- Address map:
  - RAM: 0x00000000..(4*RAM_WORDS-1).
  - 0x40000000 TH.
  - 0x40000004 TL.
  - 0x40000008 TCON[2:0].
  - 0x4000000C LED[7:0].
  - 0x40000010 switch, read-only.
  - 0x40000014 tube[17:0].
  - 0x40000018 UART_TXD[7:0].
  - 0x4000001C UART_RXD[7:0], read-only.
  - 0x40000020 UART_CON[4:0].
  - Any other address: reads 0, writes ignored.
- Reads:
  - readdata is combinational from address when read_enable=1, zero-extended to 32 bits.
  - readdata=0 when read_enable=0.
- Writes take effect on the rising clk edge when write_enable=1. RAM, TH, TL, TCON, LED, tube, TXD and UART_CON[1:0] are writable.
- Reset values:
  - led=0, tube=0, TH=0, TL=0, TCON=0, UART_CON=0, RXD=0.
  - Uart_Tx=1, if_continue=0, irq=0.
  - RAM contents are not affected by reset.
- Timer:
  - When TCON[0]=1, TL increments by 1 every clk.
  - When TL=0xFFFFFFFF, the next edge loads TL<=TH and, if TCON[1]=1, sets TCON[2]<=1 (sticky).
  - irq = TCON[1] & TCON[2].
  - A CPU write to TL or TCON in the same cycle overrides the timer update.
  - Software clears TCON[2] by writing 0 to it.
- UART_CON bits: [0] tx-irq enable, [1] rx-irq enable, [2] tx-done (sticky), [3] rx-done (sticky), [4] tx-busy (read-only).
- UART_CON read side effect: a read (read_enable=1, address 0x40000020) returns the current value, then clears bits [2] and [3] at that clk edge.
- UART TX:
  - A write to TXD while not busy latches the byte and starts an 8N1 frame: start bit 0, data LSB first, stop bit 1; each bit lasts BAUD_DIV clks.
  - tx-busy is high from the edge after the write until the end of the stop bit, then tx-done is set.
  - A TXD write while busy is ignored.
- UART RX:
  - Uart_Rx passes through a 2-flop synchronizer.
  - An idle-high-to-low transition starts reception. The start bit is re-checked at BAUD_DIV/2; if high it is a glitch and the receiver returns to idle.
  - Data bits are sampled every BAUD_DIV clks after that point, then the stop bit.
  - Stop bit 1: RXD<=byte, rx-done<=1, if_continue<=1.
  - Stop bit 0: framing error, byte discarded, no flags set.
  - Reading RXD clears if_continue on that edge.
  - A new byte overwrites RXD; a set and a clear in the same cycle resolve to set.
- Reset asserted mid-frame aborts TX/RX immediately; Uart_Tx returns high.

Test Plan:
- RAM write/read: write 0xDEADBEEF to 0x00000010, then 0x12345678 to 0x00000014; read both back, and read 0x00000012 returns 0xDEADBEEF; read_enable=0 gives readdata=0.
- LED/tube/switch: write 0x1A5 to 0x4000000C -> led=0xA5; write 0x3FFFF to 0x40000014 -> tube=0x3FFFF; switch=0x5C -> read 0x40000010 returns 0x0000005C; read of 0x40000100 returns 0.
- Timer: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> after 2 clks TL=0xFFFFFFFD and irq=1; then write TCON=1 -> irq=0 while TL keeps counting.
- UART TX (BAUD_DIV=4): write 0x55 to TXD -> Uart_Tx shows 0,1,0,1,0,1,0,1,0,1, each bit 4 clks; UART_CON[4]=1 during the frame; afterwards UART_CON reads 0x04, and a second read returns 0x00.
- UART RX (BAUD_DIV=4): drive frame 0xA3 -> if_continue=1, RXD reads 0xA3 and the read clears if_continue; a frame with stop bit 0 leaves if_continue=0.
- Reset mid-TX frame -> Uart_Tx=1, led=0, tube=0, UART_CON=0 immediately.
